// File: rtl/store_merge_unit.sv
// Store-side memory interface: executes sd/sw/sh/sb against a 64-bit memory
// without byte enables. Sub-doubleword stores read the aligned doubleword,
// merge the store bytes into their little-endian lanes and write it back.
module store_merge_unit #(
   parameter int unsigned READ_LAT = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] inst,
   input  logic [63:0] addr,
   input  logic [63:0] rs2_data,
   input  logic [63:0] mem_rdata,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   output logic        mem_wr,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam int unsigned XLEN  = 64;
   localparam int unsigned CNT_W = 4;

   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [2:0] F3_SB    = 3'b000;
   localparam logic [2:0] F3_SH    = 3'b001;
   localparam logic [2:0] F3_SW    = 3'b010;
   localparam logic [2:0] F3_SD    = 3'b011;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WRITE,
      S_DONE,
      S_FAULT
   } state_t;

   state_t            state;
   logic [2:0]        funct3_q;
   logic [XLEN-1:0]   addr_q;
   logic [XLEN-1:0]   rs2_q;
   logic [CNT_W-1:0]  cnt;
   logic              fault_c;
   logic [XLEN-1:0]   merged_c;

   // Only opcode and funct3 fields of the instruction matter here.
   logic unused_inst_bits;
   assign unused_inst_bits = ^{inst[31:15], inst[11:7]};

   // Memory is addressed by aligned doubleword of the latched address.
   assign mem_addr = {addr_q[XLEN-1:3], 3'b000};

   // Replace the addressed lane(s) of the old doubleword with store data.
   function automatic logic [XLEN-1:0] merge_lanes(input logic [2:0]      f3,
                                                    input logic [2:0]      lane,
                                                    input logic [XLEN-1:0] old,
                                                    input logic [XLEN-1:0] src);
      logic [XLEN-1:0] m;
      m = old;
      case (f3)
         F3_SB:   m[{lane, 3'b000} +: 8]          = src[7:0];
         F3_SH:   m[{lane[2:1], 4'b0000} +: 16]   = src[15:0];
         F3_SW:   m[{lane[2], 5'b00000} +: 32]    = src[31:0];
         default: m                               = src;
      endcase
      return m;
   endfunction

   // Classify an incoming request: illegal opcode/funct3 or misaligned address.
   always_comb begin
      fault_c = 1'b0;
      if (inst[6:0] != OP_STORE) begin
         fault_c = 1'b1;
      end else begin
         case (inst[14:12])
            F3_SB:   fault_c = 1'b0;
            F3_SH:   fault_c = addr[0];
            F3_SW:   fault_c = |addr[1:0];
            F3_SD:   fault_c = |addr[2:0];
            default: fault_c = 1'b1;
         endcase
      end
   end

   // Merge uses the read data present on the final READ cycle.
   always_comb begin
      merged_c = merge_lanes(funct3_q, addr_q[2:0], mem_rdata, rs2_q);
   end

   // Sequencer with registered strobes so mem_wr/done/err are glitch-free.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         funct3_q  <= '0;
         addr_q    <= '0;
         rs2_q     <= '0;
         cnt       <= '0;
         mem_wdata <= '0;
         mem_wr    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         mem_wr <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  funct3_q <= inst[14:12];
                  addr_q   <= addr;
                  rs2_q    <= rs2_data;
                  busy     <= 1'b1;
                  if (fault_c) begin
                     state <= S_FAULT;
                     done  <= 1'b1;
                     err   <= 1'b1;
                  end else if (inst[14:12] == F3_SD) begin
                     state     <= S_WRITE;
                     mem_wdata <= rs2_data;
                     mem_wr    <= 1'b1;
                  end else begin
                     state <= S_READ;
                     cnt   <= CNT_W'(READ_LAT - 1);
                  end
               end
            end
            S_READ: begin
               if (cnt == '0) begin
                  state     <= S_WRITE;
                  mem_wdata <= merged_c;
                  mem_wr    <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_WRITE: begin
               state <= S_DONE;
               done  <= 1'b1;
            end
            S_DONE, S_FAULT: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_store_merge_unit.sv
// Bench for store_merge_unit: two instances (READ_LAT=2 and READ_LAT=1) share
// stimulus; a byte-level reference model predicts each accepted store and a
// negedge monitor checks every write strobe and completion against it.
module tb_store_merge_unit;

   typedef struct {
      logic        err;
      logic [63:0] maddr;
      logic [63:0] wdata;
      int          e;
      int          lat;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] inst;
   logic [63:0] addr;
   logic [63:0] rs2_data;
   logic [63:0] mem_rdata [2];
   logic [63:0] mem_addr  [2];
   logic [63:0] mem_wdata [2];
   logic        mem_wr    [2];
   logic        busy      [2];
   logic        done      [2];
   logic        err       [2];

   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;
   int   wr_cnt [2];
   int   free_e [2];
   exp_t q [2][$];

   // Backing memory contents as a pure function of the aligned address.
   function automatic logic [63:0] rdfn(input logic [63:0] a);
      if (a < 64'h10000) return 64'h1122334455667788;
      return (a * 64'h9E3779B97F4A7C15) ^ {a[31:0], a[63:32]};
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int unsigned RL = (g == 0) ? 2 : 1;
      assign mem_rdata[g] = rdfn(mem_addr[g]);
      store_merge_unit #(.READ_LAT(RL)) u_dut (
         .clk       (clk),
         .reset     (reset),
         .start     (start),
         .inst      (inst),
         .addr      (addr),
         .rs2_data  (rs2_data),
         .mem_rdata (mem_rdata[g]),
         .mem_addr  (mem_addr[g]),
         .mem_wdata (mem_wdata[g]),
         .mem_wr    (mem_wr[g]),
         .busy      (busy[g]),
         .done      (done[g]),
         .err       (err[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s dut%0d: got 0x%h expected 0x%h at cycle %0d", nm, d, act, exp, cyc);
   endtask

   // Reference: store of 2**funct3 bytes into the addressed doubleword.
   function automatic exp_t predict(input logic [31:0] i, input logic [63:0] a,
                                    input logic [63:0] r, input int rl, input int e);
      exp_t        x;
      int          size;
      int          lo;
      logic [7:0]  b [8];
      logic [63:0] rd;
      size    = 1 << int'(i[14:12]);
      lo      = int'(a[2:0]);
      x.e     = e;
      x.maddr = a & ~64'h7;
      x.wdata = '0;
      x.err   = (i[6:0] != 7'b0100011) || (i[14:12] > 3'd3) || ((lo % size) != 0);
      if (x.err) begin
         x.lat = 1;
         return x;
      end
      rd = rdfn(x.maddr);
      for (int k = 0; k < 8; k++) b[k] = rd[8*k +: 8];
      for (int k = 0; k < size; k++) b[lo + k] = r[8*k +: 8];
      for (int k = 0; k < 8; k++) x.wdata[8*k +: 8] = b[k];
      x.lat = (size == 8) ? 2 : rl + 2;
      return x;
   endfunction

   function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] op);
      return {17'($urandom), f3, 5'($urandom), op};
   endfunction

   function automatic logic [31:0] rnd_inst();
      logic [6:0] op;
      logic [2:0] f3;
      op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : 7'b0100011;
      f3 = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'($urandom_range(0, 3));
      return mk(f3, op);
   endfunction

   function automatic logic [63:0] rnd_addr(input logic [2:0] f3);
      logic [63:0] a;
      a = {32'($urandom), 32'($urandom)};
      if ($urandom_range(0, 3) != 0) begin
         case (f3)
            3'd1:    a[0]   = 1'b0;
            3'd2:    a[1:0] = 2'b00;
            3'd3:    a[2:0] = 3'b000;
            default: ;
         endcase
      end
      return a;
   endfunction

   // Apply inputs for one cycle; record a prediction for each unit that is idle.
   task automatic drive(input bit s, input logic [31:0] i, input logic [63:0] a, input logic [63:0] r);
      exp_t x;
      int   e;
      start    = s;
      inst     = i;
      addr     = a;
      rs2_data = r;
      e        = cyc + 1;
      if (s && !reset) begin
         for (int d = 0; d < 2; d++) begin
            if (e >= free_e[d]) begin
               x = predict(i, a, r, (d == 0) ? 2 : 1, e);
               q[d].push_back(x);
               free_e[d] = e + x.lat + 1;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive_rand(input bit s);
      logic [31:0] i;
      i = rnd_inst();
      drive(s, i, rnd_addr(i[14:12]), {32'($urandom), 32'($urandom)});
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q[0].size() != 0 || q[1].size() != 0) && n < 200) begin
         drive_rand(1'b0);
         n++;
      end
      chk("drain_outstanding", 0, 64'(q[0].size() + q[1].size()), 64'd0);
      drive_rand(1'b0);
   endtask

   task automatic one(input logic [2:0] f3, input logic [6:0] op, input logic [63:0] a, input logic [63:0] r);
      drive(1'b1, mk(f3, op), a, r);
      drain();
   endtask

   task automatic chk_zero(input string tag);
      for (int d = 0; d < 2; d++) begin
         chk({tag, "_mem_addr"}, d, mem_addr[d], 64'd0);
         chk({tag, "_mem_wdata"}, d, mem_wdata[d], 64'd0);
         chk({tag, "_mem_wr"}, d, 64'(mem_wr[d]), 64'd0);
         chk({tag, "_busy"}, d, 64'(busy[d]), 64'd0);
         chk({tag, "_done"}, d, 64'(done[d]), 64'd0);
         chk({tag, "_err"}, d, 64'(err[d]), 64'd0);
      end
   endtask

   // Start an sb, wait, then hit reset; outputs must clear without a completion.
   task automatic reset_mid(input int waits, input bit in_write, input string tag);
      drive(1'b1, mk(3'b000, 7'b0100011), 64'h7003, 64'h5A);
      repeat (waits) drive_rand(1'b0);
      if (in_write) chk({tag, "_pre_wr"}, 0, 64'(mem_wr[0]), 64'd1);
      reset = 1'b1;
      #1;
      chk_zero(tag);
      for (int d = 0; d < 2; d++) begin
         q[d].delete();
         wr_cnt[d] = 0;
         free_e[d] = 0;
      end
      drive_rand(1'b1);
      drive_rand(1'b0);
      reset = 1'b0;
      drive_rand(1'b0);
   endtask

   // Monitor: compare every write strobe and completion with the prediction queue.
   always @(negedge clk) begin
      exp_t f;
      bit   have;
      if (!reset) begin
         for (int d = 0; d < 2; d++) begin
            have = q[d].size() > 0;
            if (have) f = q[d][0];
            chk("busy", d, 64'(busy[d]), 64'(have && cyc >= f.e));
            if (mem_wr[d]) begin
               chk("wr_expected", d, 64'(have), 64'd1);
               if (have) begin
                  chk("wr_on_fault", d, 64'(f.err), 64'd0);
                  chk("wr_cycle", d, 64'(cyc), 64'(f.e + f.lat - 2));
                  chk("wr_addr", d, mem_addr[d], f.maddr);
                  chk("wr_data", d, mem_wdata[d], f.wdata);
               end
               wr_cnt[d]++;
            end
            if (done[d]) begin
               chk("done_expected", d, 64'(have), 64'd1);
               if (have) begin
                  chk("done_cycle", d, 64'(cyc), 64'(f.e + f.lat - 1));
                  chk("done_err", d, 64'(err[d]), 64'(f.err));
                  chk("wr_count", d, 64'(wr_cnt[d]), 64'(!f.err));
                  void'(q[d].pop_front());
               end
               wr_cnt[d] = 0;
            end else begin
               chk("err_without_done", d, 64'(err[d]), 64'd0);
            end
         end
      end
   end

   initial begin
      wr_cnt[0] = 0;
      wr_cnt[1] = 0;
      free_e[0] = 0;
      free_e[1] = 0;
      reset     = 1'b1;
      start     = 1'b0;
      inst      = '0;
      addr      = '0;
      rs2_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_zero("reset");
      reset = 1'b0;
      drive_rand(1'b0);

      // Directed stores and faults
      one(3'b000, 7'b0100011, 64'h1003, 64'h00000000000000AB);
      one(3'b001, 7'b0100011, 64'h2006, 64'h00000000FFFFBEEF);
      one(3'b010, 7'b0100011, 64'h3004, 64'h00000000DEADBEEF);
      one(3'b011, 7'b0100011, 64'h4000, 64'h0123456789ABCDEF);
      one(3'b010, 7'b0100011, 64'h3002, 64'h00000000DEADBEEF);
      one(3'b001, 7'b0100011, 64'h0005, 64'h1234);
      one(3'b011, 7'b0100011, 64'h4004, 64'h0123456789ABCDEF);
      one(3'b100, 7'b0100011, 64'h1000, 64'h77);
      one(3'b000, 7'b0000011, 64'h1000, 64'h77);
      one(3'b000, 7'b0100011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hC3);

      // Start held high: exercises ignored starts and back-to-back acceptance
      repeat (30) drive_rand(1'b1);
      drain();

      // Reset during READ, then during WRITE
      reset_mid(0, 1'b0, "rst_read");
      reset_mid(2, 1'b1, "rst_write");
      one(3'b000, 7'b0100011, 64'h1003, 64'h00000000000000AB);

      // Random traffic
      for (int n = 0; n < 400; n++) drive_rand($urandom_range(0, 9) < 4);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/store_merge_unit.md
Name: store_merge_unit

Overview:
Store-side memory interface for the 64-bit RISC-V datapath: executes sd/sw/sh/sb against a 64-bit memory with no byte enables. It is the write-direction counterpart of the load-extraction path.
Sub-doubleword stores use a read-modify-write sequence: fetch the aligned doubleword, merge the rs2 bytes into the addressed lanes, write back. The control unit starts the block for opcode 0100011 and stalls on busy until done.

Parameters:
READ_LAT, 2, cycles mem_addr is held in READ before mem_rdata is sampled (legal range 1..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle request; sampled only in IDLE
inst  input  32  current instruction; opcode inst[6:0], funct3 inst[14:12]
addr  input  64  effective byte address (rs1+imm)
rs2_data  input  64  store source register
mem_rdata  input  64  doubleword read data from memory
mem_addr  output  64  aligned doubleword address {addr_q[63:3],3'b000}
mem_wdata  output  64  doubleword write data
mem_wr  output  1  memory write strobe, one cycle per store
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle completion pulse
err  output  1  one-cycle pulse coincident with done on illegal/misaligned request

Behaviour:
- Reset (async, immediate): state=IDLE, mem_addr=0, mem_wdata=0, mem_wr=0, busy=0, done=0, err=0, latched operands=0, read counter=0.
- States: IDLE, READ, WRITE, DONE, FAULT.
- IDLE: when start=1, latch inst funct3/opcode, addr, rs2_data on the clock edge, then classify:
  - opcode != 0100011, or funct3 not in {000 sb, 001 sh, 010 sw, 011 sd} -> FAULT.
  - Misaligned -> FAULT: sh with addr[0]=1; sw with addr[1:0]!=0; sd with addr[2:0]!=0.
  - sd aligned -> WRITE (no read).
  - sb/sh/sw aligned -> READ, counter loaded with READ_LAT-1.
- READ: mem_addr driven, mem_wr=0. Counter decrements each cycle.
  - When counter==0, at that edge: register mem_wdata = merge(mem_rdata), go to WRITE.
  - Total READ occupancy is exactly READ_LAT cycles.
- Merge (little-endian lanes; all bytes not written keep their mem_rdata value):
  - sb: byte lane addr[2:0] <= rs2[7:0].
  - sh: halfword lane addr[2:1] <= rs2[15:0].
  - sw: word lane addr[2] <= rs2[31:0].
  - sd: mem_wdata <= rs2_data, registered on the IDLE->WRITE edge.
- WRITE: mem_wr=1 for exactly this one cycle; mem_addr and mem_wdata stable. Next state DONE.
- DONE: done=1, err=0, mem_wr=0. Next state IDLE.
- FAULT: done=1, err=1, mem_wr=0. Next state IDLE. No memory access of any kind.
- Outputs mem_wr, done, err are decoded from registered state, glitch-free.
- busy=1 in READ/WRITE/DONE/FAULT. start while busy is ignored and not queued. start in the same cycle done is high is also ignored (state is not IDLE).
- mem_addr, mem_wdata hold their last values in IDLE.
- Latency, start edge to done high:
  - sd: 2 cycles.
  - sb/sh/sw: READ_LAT+2 cycles.
  - fault: 1 cycle.
- Inputs inst/addr/rs2_data may change after the start edge without effect.
- Reset mid-operation, including during WRITE: mem_wr drops immediately, no done/err pulse, state=IDLE. A write interrupted mid-cycle is the system's responsibility, not retried.
- Addresses wrap naturally; no range checking.

Test Plan:
- sb, READ_LAT=2, addr=0x1003, rs2=0xAB, mem_rdata=0x1122334455667788 -> one mem_wr at mem_addr=0x1000, mem_wdata=0x11223344AB667788, done 4 cycles after start, err=0.
- sh addr=0x2006, rs2=0xFFFF_BEEF, same mem_rdata -> mem_wdata=0xBEEF334455667788, mem_addr=0x2000; sw addr=0x3004, rs2=0xDEADBEEF -> 0xDEADBEEF55667788.
- sd addr=0x4000, rs2=0x0123456789ABCDEF -> mem_wr the cycle after start with that exact wdata, zero READ cycles, done 2 cycles after start.
- Misaligned sw addr=0x3002; sh addr=0x5; sd addr=0x4004; illegal funct3=100 -> done+err pulse 1 cycle after start, mem_wr never asserted.
- start pulsed again during READ and on the done cycle -> ignored, exactly one mem_wr. Back-to-back: start the cycle after done -> accepted.
- reset asserted in READ and again in WRITE -> all outputs 0 asynchronously, no done. Next store after reset completes normally. Repeat sb with READ_LAT=1 -> done 3 cycles after start.
